ula_lo_seq: RTL and testbench
=============================

Name: ula_lo_seq

Overview:
- Parametrised, clocked successor of the team's combinational logic/shift ALU.
- Keeps the same 5-bit opcode encodings and O/C/S/Z flag semantics.
- Generalises data width to WIDTH and adds multi-bit shifts/rotates, executed iteratively one bit per cycle.
- Operands arrive on a valid/ready handshake; results and flags are registered on a valid/ready output handshake with backpressure. Sits between the operand-fetch stage and writeback of the datapath.

Parameters:
WIDTH, 8, data width in bits (>=2)
SHW, $clog2(WIDTH), shift-amount width; legal shift amounts are 0..WIDTH-1

Ports:
CLK  in  1  clock, rising edge
RST_N  in  1  reset, asynchronous, active-low
IN_VALID  in  1  operands/opcode valid
IN_READY  out  1  block can accept an operation
A  in  WIDTH  operand A (value to shift for shift ops)
B  in  WIDTH  operand B
SHAMT  in  SHW  shift/rotate amount (ignored for logic ops)
OP  in  5  opcode
OUT_VALID  out  1  RESU/flags hold a completed result
OUT_READY  in  1  consumer accepts the result
RESU  out  WIDTH  result
O, C, S, Z  out  1 each  overflow, carry, sign, zero flags
BUSY  out  1  high in SHIFT state

Behaviour:
- Clock and reset: one clock CLK; RST_N is asynchronous and active-low.
- Reset: state=IDLE, RESU=0, O=C=S=Z=0, OUT_VALID=0, count=0. Applies immediately, including mid-shift; any operation in flight is discarded.
- FSM states: IDLE, SHIFT, DONE.
  - IN_READY=1 only in IDLE. OUT_VALID=1 only in DONE. BUSY=1 only in SHIFT.
- Accept: on an edge E0 in IDLE with IN_VALID=1.
  - Logic op: RESU is computed from A/B and registered at E0; go to DONE.
  - Shift op: working reg=A, count=SHAMT, C cleared, O cleared. Go to SHIFT if SHAMT>0, else DONE with RESU=A.
- SHIFT: each edge performs one 1-bit step and decrements count. When count reaches 0 after the step, go to DONE. OUT_VALID is therefore first visible after edge E0+SHAMT; logic ops are visible after E0.
- DONE: RESU and flags held stable while OUT_READY=0. On an edge with OUT_READY=1, go to IDLE. No new op is accepted in that same cycle; max throughput is 1 op per 2 cycles.
- Inputs A/B/SHAMT/OP are sampled only at accept; later changes are ignored.
- Shift opcodes (one bit per step; C = last bit shifted out):
  - 01000 LSL: O set (sticky) if the MSB changes on any step.
  - 01001 ASR: MSB replicated.
  - 01010 LSR: zero fill.
  - 01011 ROR: MSB takes the old LSB; C = that bit.
  - For ROR/LSR/ASR, O is cleared at accept. For SHAMT=0, C=0 and O=0.
- Logic opcodes; C and O are unchanged for all of them:
  - 10000 zero, 10001 A&B, 10010 ~A&B, 10011 pass B, 10100 A&~B, 10101 pass A, 10110 A^B, 10111 A|B.
  - 11000 ~A&~B, 11001 ~(A^B), 11010 ~A, 11011 ~A|B, 11100 ~B, 11101 A|~B, 11110 ~A|~B, 11111 constant 1.
- Any other opcode: RESU = OP zero-extended to WIDTH (truncated if WIDTH<5); treated as a logic op.
- Z/S update rules, applied when the result enters DONE:
  - 10011 and 11111: Z and S keep their previous values.
  - 10000: Z updated, S unchanged.
  - All other ops: Z = (RESU==0), S = RESU[WIDTH-1].
- Flags persist across IDLE until the next completing op or reset.
- SHAMT >= WIDTH is not possible by width; the full range 0..2^SHW-1 is legal, and values above WIDTH-1 simply iterate (ROR wraps, LSL/LSR yield 0).

Decomposition:
- Package ula_lo_pkg holds:
  - the op_e enum with all 5-bit opcode constants above;
  - the state_e enum (IDLE/SHIFT/DONE);
  - the function is_shift(op).
- One natural sub-module, ula_lo_logic: purely combinational WIDTH-parametrised logic-op evaluator (A, B, OP -> result). It is instantiated once; the FSM, counter, shift step and flag registers live in ula_lo_seq.

Test Plan:
1. WIDTH=8, LSL A=0xC1 SHAMT=3 -> BUSY for 3 cycles; OUT_VALID after E0+3; RESU=0x08, C=0, O=1, S=0, Z=0.
2. ASR A=0x90 SHAMT=4 -> RESU=0xF9, C=0, S=1, Z=0. Then ROR A=0x01 SHAMT=1 -> RESU=0x80, C=1, S=1.
3. XOR A=B=0x55 -> RESU=0x00, Z=1, OUT_VALID after E0. Next, op 11111 -> RESU=0x01, Z stays 1, S stays 0. Next, op 10000 after a result with S=1 -> RESU=0, Z=1, S stays 1.
4. AND A=0xF0 B=0x3C with OUT_READY=0 for 5 cycles -> RESU=0x30 held; IN_READY=0 throughout. IN_VALID with new operands is ignored until the handshake plus one IDLE cycle.
5. LSL SHAMT=0 A=0x7F -> DONE after E0, RESU=0x7F, C=0, O=0. Illegal OP=5'b00011 -> RESU=0x03, Z=0.
6. Assert RST_N=0 asynchronously mid-LSL (count=2) -> all outputs 0 and state IDLE immediately, with no OUT_VALID pulse. After release, IN_READY=1 on the next cycle.

Source files
------------

// File: rtl/ula_lo_pkg.sv
// Shared opcode, state and helper definitions for the sequential logic/shift ALU.
package ula_lo_pkg;

    typedef enum logic [4:0] {
        OP_LSL   = 5'b01000,
        OP_ASR   = 5'b01001,
        OP_LSR   = 5'b01010,
        OP_ROR   = 5'b01011,
        OP_ZERO  = 5'b10000,
        OP_AND   = 5'b10001,
        OP_NAANDB = 5'b10010,
        OP_PASSB = 5'b10011,
        OP_AANDNB = 5'b10100,
        OP_PASSA = 5'b10101,
        OP_XOR   = 5'b10110,
        OP_OR    = 5'b10111,
        OP_NOR   = 5'b11000,
        OP_XNOR  = 5'b11001,
        OP_NOTA  = 5'b11010,
        OP_NAORB = 5'b11011,
        OP_NOTB  = 5'b11100,
        OP_AORNB = 5'b11101,
        OP_NAND  = 5'b11110,
        OP_ONE   = 5'b11111
    } op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    // Shift/rotate opcodes occupy 01000..01011.
    function automatic logic is_shift(input logic [4:0] op);
        return op[4:2] == 3'b010;
    endfunction

endpackage

// File: rtl/ula_lo_seq_if.sv
// Operand and result handshake bundle of the sequential logic/shift ALU.
interface ula_lo_seq_if #(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [SHW-1:0]   shamt;
    logic [4:0]       op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] resu;
    logic             o;
    logic             c;
    logic             s;
    logic             z;
    logic             busy;

    modport master (
        output in_valid, a, b, shamt, op, out_ready,
        input  in_ready, out_valid, resu, o, c, s, z, busy
    );

    modport slave (
        input  in_valid, a, b, shamt, op, out_ready,
        output in_ready, out_valid, resu, o, c, s, z, busy
    );
endinterface

// File: rtl/ula_lo_logic.sv
// Combinational logic-op evaluator; unknown opcodes yield the opcode itself.
module ula_lo_logic
    import ula_lo_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [4:0]       op,
    output logic [WIDTH-1:0] res
);
    logic [WIDTH-1:0] dflt;

    // Opcode zero-extended, or truncated when the datapath is narrower than 5 bits.
    generate
        if (WIDTH >= 5) begin : g_ext
            assign dflt = WIDTH'(op);
        end else begin : g_trunc
            assign dflt = op[WIDTH-1:0];
        end
    endgenerate

    // Select the logic function for the opcode.
    always_comb begin
        res = dflt;
        case (op)
            OP_ZERO:   res = '0;
            OP_AND:    res = a & b;
            OP_NAANDB: res = ~a & b;
            OP_PASSB:  res = b;
            OP_AANDNB: res = a & ~b;
            OP_PASSA:  res = a;
            OP_XOR:    res = a ^ b;
            OP_OR:     res = a | b;
            OP_NOR:    res = ~a & ~b;
            OP_XNOR:   res = ~(a ^ b);
            OP_NOTA:   res = ~a;
            OP_NAORB:  res = ~a | b;
            OP_NOTB:   res = ~b;
            OP_AORNB:  res = a | ~b;
            OP_NAND:   res = ~a | ~b;
            OP_ONE:    res = WIDTH'(1);
            default:   res = dflt;
        endcase
    end
endmodule

// File: rtl/ula_lo_seq.sv
// Sequential logic/shift ALU: one op at a time, shifts iterate one bit per clock.
module ula_lo_seq
    import ula_lo_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input logic         clk,
    input logic         rst_n,
    ula_lo_seq_if.slave bus
);
    state_e           state;
    logic [4:0]       op_q;
    logic [WIDTH-1:0] work;
    logic [SHW-1:0]   cnt;
    logic [WIDTH-1:0] resu_q;
    logic             o_q, c_q, s_q, z_q;
    logic             in_ready_q, out_valid_q, busy_q;

    logic [WIDTH-1:0] step;
    logic             step_c;
    logic             step_ov;
    logic [WIDTH-1:0] logic_res;

    ula_lo_logic #(.WIDTH(WIDTH)) u_logic (
        .a   (bus.a),
        .b   (bus.b),
        .op  (bus.op),
        .res (logic_res)
    );

    // One-bit shift/rotate step of the working register.
    always_comb begin
        step    = work;
        step_c  = 1'b0;
        step_ov = 1'b0;
        case (op_q)
            OP_LSL: begin
                step    = {work[WIDTH-2:0], 1'b0};
                step_c  = work[WIDTH-1];
                step_ov = work[WIDTH-1] ^ work[WIDTH-2];
            end
            OP_ASR: begin
                step   = {work[WIDTH-1], work[WIDTH-1:1]};
                step_c = work[0];
            end
            OP_LSR: begin
                step   = {1'b0, work[WIDTH-1:1]};
                step_c = work[0];
            end
            OP_ROR: begin
                step   = {work[0], work[WIDTH-1:1]};
                step_c = work[0];
            end
            default: begin
                step    = work;
                step_c  = 1'b0;
                step_ov = 1'b0;
            end
        endcase
    end

    // Control FSM with registered handshake outputs, result and flags.
    // in_ready resets low and rises on the first IDLE edge, so outputs read 0 in reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            op_q        <= '0;
            work        <= '0;
            cnt         <= '0;
            resu_q      <= '0;
            o_q         <= 1'b0;
            c_q         <= 1'b0;
            s_q         <= 1'b0;
            z_q         <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_ready_q && bus.in_valid) begin
                        in_ready_q <= 1'b0;
                        op_q       <= bus.op;
                        if (is_shift(bus.op)) begin
                            work <= bus.a;
                            cnt  <= bus.shamt;
                            c_q  <= 1'b0;
                            o_q  <= 1'b0;
                            if (bus.shamt != '0) begin
                                state  <= SHIFT;
                                busy_q <= 1'b1;
                            end else begin
                                state       <= DONE;
                                out_valid_q <= 1'b1;
                                resu_q      <= bus.a;
                                z_q         <= (bus.a == '0);
                                s_q         <= bus.a[WIDTH-1];
                            end
                        end else begin
                            state       <= DONE;
                            out_valid_q <= 1'b1;
                            resu_q      <= logic_res;
                            if (bus.op == OP_ZERO) begin
                                z_q <= (logic_res == '0);
                            end else if (bus.op != OP_PASSB && bus.op != OP_ONE) begin
                                z_q <= (logic_res == '0);
                                s_q <= logic_res[WIDTH-1];
                            end
                        end
                    end else begin
                        in_ready_q <= 1'b1;
                    end
                end
                SHIFT: begin
                    work <= step;
                    cnt  <= cnt - 1'b1;
                    c_q  <= step_c;
                    if (step_ov) begin
                        o_q <= 1'b1;
                    end
                    if (cnt == SHW'(1)) begin
                        state       <= DONE;
                        busy_q      <= 1'b0;
                        out_valid_q <= 1'b1;
                        resu_q      <= step;
                        z_q         <= (step == '0);
                        s_q         <= step[WIDTH-1];
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state       <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state       <= IDLE;
                    busy_q      <= 1'b0;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;
    assign bus.resu      = resu_q;
    assign bus.o         = o_q;
    assign bus.c         = c_q;
    assign bus.s         = s_q;
    assign bus.z         = z_q;
endmodule

// File: tb/tb_ula_lo_seq.sv
// Scoreboard bench for ula_lo_seq at WIDTH=8.
module tb_ula_lo_seq;
    import ula_lo_pkg::*;

    typedef struct packed {
        logic [7:0] resu;
        logic       c;
        logic       o;
        logic       s;
        logic       z;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;
    exp_t sb[$];
    logic m_c, m_o, m_s, m_z;

    ula_lo_seq_if #(.WIDTH(8), .SHW(3)) ifc ();

    ula_lo_seq #(.WIDTH(8), .SHW(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference behaviour; updates the bench's own flag state.
    task automatic model_op(input logic [4:0] op, input logic [7:0] a, input logic [7:0] b,
                            input logic [2:0] sh, output logic [7:0] r);
        logic [15:0] dd;
        int          n;
        n = int'(sh);
        r = 8'h00;
        if (op[4:2] == 3'b010) begin
            m_c = 1'b0;
            m_o = 1'b0;
            case (op[1:0])
                2'b00: begin
                    r = a << n;
                    if (n > 0) m_c = a[8-n];
                    for (int i = 1; i <= n; i++) if (a[7-i] != a[7]) m_o = 1'b1;
                end
                2'b01: begin
                    r = $signed(a) >>> n;
                    if (n > 0) m_c = a[n-1];
                end
                2'b10: begin
                    r = a >> n;
                    if (n > 0) m_c = a[n-1];
                end
                default: begin
                    dd = {a, a} >> n;
                    r  = dd[7:0];
                    if (n > 0) m_c = a[n-1];
                end
            endcase
            m_z = (r == 8'h00);
            m_s = r[7];
        end else begin
            case (op)
                5'b10000: r = 8'h00;
                5'b10001: r = a & b;
                5'b10010: r = ~a & b;
                5'b10011: r = b;
                5'b10100: r = a & ~b;
                5'b10101: r = a;
                5'b10110: r = a ^ b;
                5'b10111: r = a | b;
                5'b11000: r = ~(a | b);
                5'b11001: r = ~(a ^ b);
                5'b11010: r = ~a;
                5'b11011: r = ~a | b;
                5'b11100: r = ~b;
                5'b11101: r = a | ~b;
                5'b11110: r = ~(a & b);
                5'b11111: r = 8'h01;
                default:  r = {3'b000, op};
            endcase
            if (op == 5'b10000) begin
                m_z = 1'b1;
            end else if (op != 5'b10011 && op != 5'b11111) begin
                m_z = (r == 8'h00);
                m_s = r[7];
            end
        end
    endtask

    task automatic run_op(input logic [4:0] op, input logic [7:0] a, input logic [7:0] b,
                          input logic [2:0] sh, input int hold);
        int         n;
        int         lat_exp;
        logic [7:0] r;
        exp_t       e;
        @(negedge clk);
        n = 0;
        while (!ifc.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_val("in_ready_wait", ifc.in_ready, 1);
        ifc.in_valid = 1'b1;
        ifc.op       = op;
        ifc.a        = a;
        ifc.b        = b;
        ifc.shamt    = sh;
        model_op(op, a, b, sh, r);
        sb.push_back('{resu: r, c: m_c, o: m_o, s: m_s, z: m_z});
        lat_exp = (op[4:2] == 3'b010) ? int'(sh) : 0;
        @(posedge clk);
        #1;
        ifc.in_valid = 1'b0;
        ifc.a        = 8'($urandom);
        ifc.b        = 8'($urandom);
        ifc.shamt    = 3'($urandom);
        ifc.op       = 5'($urandom);
        n = 0;
        while (!ifc.out_valid && n < 40) begin
            check_val("busy_in_shift", ifc.busy, 1);
            @(posedge clk);
            #1;
            n++;
        end
        check_val("latency", n, lat_exp);
        check_val("busy_done", ifc.busy, 0);
        check_val("in_ready_done", ifc.in_ready, 0);
        if (sb.size() == 0) begin
            check_val("sb_empty", 1, 0);
        end else begin
            e = sb.pop_front();
            check_val("resu", ifc.resu, e.resu);
            check_val("c", ifc.c, e.c);
            check_val("o", ifc.o, e.o);
            check_val("s", ifc.s, e.s);
            check_val("z", ifc.z, e.z);
            for (int i = 0; i < hold; i++) begin
                ifc.in_valid = 1'b1;
                @(posedge clk);
                #1;
                check_val("hold_resu", ifc.resu, e.resu);
                check_val("hold_valid", ifc.out_valid, 1);
                check_val("hold_in_ready", ifc.in_ready, 0);
            end
        end
        ifc.in_valid  = 1'b0;
        ifc.out_ready = 1'b1;
        @(posedge clk);
        #1;
        ifc.out_ready = 1'b0;
        check_val("post_hs_valid", ifc.out_valid, 0);
        check_val("post_hs_in_ready", ifc.in_ready, 1);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        m_c = 1'b0; m_o = 1'b0; m_s = 1'b0; m_z = 1'b0;
        rst_n         = 1'b0;
        ifc.in_valid  = 1'b0;
        ifc.out_ready = 1'b0;
        ifc.a         = '0;
        ifc.b         = '0;
        ifc.shamt     = '0;
        ifc.op        = '0;
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_resu", ifc.resu, 0);
        check_val("rst_flags", {ifc.o, ifc.c, ifc.s, ifc.z}, 0);
        check_val("rst_valid", ifc.out_valid, 0);
        check_val("rst_busy", ifc.busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_val("rel_in_ready", ifc.in_ready, 1);

        run_op(5'b01000, 8'hC1, 8'h00, 3'd3, 0);  // LSL -> 08, O=1
        run_op(5'b01001, 8'h90, 8'h00, 3'd4, 0);  // ASR -> F9
        run_op(5'b01011, 8'h01, 8'h00, 3'd1, 0);  // ROR -> 80, C=1
        run_op(5'b10000, 8'hAA, 8'h55, 3'd0, 0);  // zero, S stays 1
        run_op(5'b10110, 8'h55, 8'h55, 3'd0, 0);  // XOR -> 00, Z=1
        run_op(5'b11111, 8'h12, 8'h34, 3'd0, 0);  // const 1, Z/S kept
        run_op(5'b10001, 8'hF0, 8'h3C, 3'd0, 5);  // AND held under backpressure
        run_op(5'b01000, 8'h7F, 8'h00, 3'd0, 0);  // LSL by 0
        run_op(5'b00011, 8'hFF, 8'hFF, 3'd0, 0);  // illegal opcode
        run_op(5'b01010, 8'h81, 8'h00, 3'd7, 0);  // LSR by 7
        run_op(5'b01011, 8'hA5, 8'h00, 3'd7, 1);  // ROR by 7
        run_op(5'b10011, 8'h00, 8'h80, 3'd0, 0);  // pass B keeps Z/S

        for (int k = 0; k < 16; k++) begin
            run_op(5'($urandom_range(0, 31)), 8'($urandom), 8'($urandom), 3'($urandom), k % 3);
        end

        // Reset in the middle of a shift.
        @(negedge clk);
        ifc.in_valid = 1'b1;
        ifc.op       = 5'b01000;
        ifc.a        = 8'hC1;
        ifc.shamt    = 3'd3;
        @(posedge clk);
        #1;
        ifc.in_valid = 1'b0;
        check_val("mid_busy", ifc.busy, 1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        m_c = 1'b0; m_o = 1'b0; m_s = 1'b0; m_z = 1'b0;
        #1;
        check_val("ares_resu", ifc.resu, 0);
        check_val("ares_flags", {ifc.o, ifc.c, ifc.s, ifc.z}, 0);
        check_val("ares_busy", ifc.busy, 0);
        check_val("ares_valid", ifc.out_valid, 0);
        check_val("ares_in_ready", ifc.in_ready, 0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check_val("ares_hold_valid", ifc.out_valid, 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_val("ares_rel_in_ready", ifc.in_ready, 1);
        check_val("ares_rel_valid", ifc.out_valid, 0);
        run_op(5'b10111, 8'h0F, 8'h80, 3'd0, 0);  // OR after reset

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
